data_stack: RTL and testbench
=============================

# data_stack

Data stack of the 16-bit Forth core: holds the top-of-stack register T and the entries beneath it. It is the operand source and result sink of the ULA. T drives the ULA's T input and N (next-on-stack) drives the Y bus. The ULA Result comes back through `din` and is committed by the operation the control unit selects on `op`.

## Interface
- `DATA_WIDTH`, 16, width of every stack cell.
- `DEPTH`, 16, total capacity in cells, T included; power of two, ≥ 4.
- `PTR_WIDTH`, 5, width of `count`; must hold 0..DEPTH (log2(DEPTH)+1).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  3  stack operation for this cycle (encoding below).
- `din`  in  DATA_WIDTH  value to push or write into T; normally the ULA Result.
- `err_clr`  in  1  clears sticky error flags.
- `T`  out  DATA_WIDTH  top of stack, registered.
- `N`  out  DATA_WIDTH  second cell, combinational from storage; 0 when count < 2.
- `count`  out  PTR_WIDTH  number of valid cells, registered.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `tz`  out  1  T == 0, for conditional branches.
- `overflow`  out  1  sticky, push attempted while full.
- `underflow`  out  1  sticky, operation needed more cells than present.

## Operation
- Storage: T register plus array `mem[0..DEPTH-2]`. Cell k below T (k ≥ 1) is `mem[count-1-k]`, so N = `mem[count-2]`.
- `op` encoding:
  - 000 HOLD: no change.
  - 001 PUSH: `mem[count-1]` ← T if count ≥ 1; T ← din; count+1. Requires count < DEPTH.
  - 010 POP (DROP): T ← N (0 if count == 1); count−1. Requires count ≥ 1.
  - 011 REPLACE: T ← din; count unchanged. Unary ULA result. Requires count ≥ 1.
  - 100 COLLAPSE: T ← din; count−1. Binary ULA result consumes T and N. Requires count ≥ 2.
  - 101 SWAP: T ← N; `mem[count-2]` ← T. Requires count ≥ 2.
  - 110, 111: treated as HOLD; no error raised.
- Precondition violated: storage, T and count are unchanged. PUSH sets `overflow`; every other operation sets `underflow`.
- Error flags:
  - Set on the edge following the faulting cycle; remain set until `err_clr`.
  - `err_clr` together with a new fault in the same cycle: the flag ends up set (set wins).
- Errors never block later operations; the stack continues from its unchanged state.
- Cells at or above `mem[count-1]` are don't-care. N masks to 0 when count < 2, so stale data is never exposed.
- Arithmetic: count is updated with plain add/subtract. It never wraps, because the guards forbid it.

## Timing
- Reset (async assert, takes effect immediately): T = 0, count = 0, overflow = 0, underflow = 0. This gives empty = 1, full = 0, tz = 1, N = 0. `mem` contents are not reset.
- Reset deasserted: the first operation is sampled on the next rising edge.
- Every operation completes in one cycle. T, count and storage update on the rising edge and are visible right after it.
- N, empty, full and tz are combinational from registered state. No input-to-output combinational path exists; the ULA loop `T/N → ULA → din` is closed through the T register only.
- Back-to-back operations every cycle are legal, including PUSH immediately followed by POP/SWAP reading the just-written cell.
- Reset asserted mid-sequence: all state is discarded at once. Prior contents are not recoverable (count = 0).

## Test plan
- Reset, then PUSH 0x0011, 0x0022, 0x0033 on consecutive cycles → T = 0x0033, N = 0x0022, count = 3, tz = 0, empty = 0.
- With 0x0033/0x0022 on top, COLLAPSE with din = 0x0055 → T = 0x0055, N = 0x0011, count = 2. Then SWAP → T = 0x0011, N = 0x0055.
- PUSH 16 values 1..16 → full = 1, T = 16. A 17th PUSH of 0xBEEF → overflow = 1, T = 16, count = 16. Then 16 POPs → count = 0, T = 0, tz = 1, and the POP that empties the stack leaves N = 0.
- On an empty stack, issue POP, then REPLACE, then SWAP → underflow = 1 after the first. T = 0 and count = 0 throughout. err_clr with no fault → underflow = 0. err_clr in the same cycle as POP on empty → underflow stays 1.
- count = 1, T = 0x00AA: SWAP → underflow = 1, T unchanged. REPLACE din = 0x0000 → T = 0, tz = 1, count = 1. op = 110 → nothing changes.
- Assert rst asynchronously between clock edges with count = 5 → T = 0, count = 0, empty = 1 immediately, before the next clk edge.

Source files
------------

// File: rtl/data_stack_if.sv
// Operation/result bundle between the control unit and the data stack.
// The control unit drives op/din/err_clr; the stack drives everything else.
interface data_stack_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PTR_WIDTH  = 5
);
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] din;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] T;
  logic [DATA_WIDTH-1:0] N;
  logic [PTR_WIDTH-1:0]  count;
  logic                  empty;
  logic                  full;
  logic                  tz;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output op, din, err_clr,
    input  T, N, count, empty, full, tz, overflow, underflow
  );

  modport slave (
    input  op, din, err_clr,
    output T, N, count, empty, full, tz, overflow, underflow
  );
endinterface

// File: rtl/data_stack.sv
// Forth data stack: registered top-of-stack T over a cell array holding the
// entries beneath it. One operation per cycle, sticky overflow/underflow flags.
module data_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 5
) (
  input logic         clk,
  input logic         rst,
  data_stack_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD     = 3'b000,
    OP_PUSH     = 3'b001,
    OP_POP      = 3'b010,
    OP_REPLACE  = 3'b011,
    OP_COLLAPSE = 3'b100,
    OP_SWAP     = 3'b101,
    OP_RSVD6    = 3'b110,
    OP_RSVD7    = 3'b111
  } op_e;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];

  logic [DATA_WIDTH-1:0] t_reg, t_next;
  logic [PTR_WIDTH-1:0]  count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ovf_set, unf_set;

  logic [ADDR_WIDTH-1:0] addr_top;  // mem[count-1]: slot that receives T on PUSH
  logic [ADDR_WIDTH-1:0] addr_n;    // mem[count-2]: current N
  logic [DATA_WIDTH-1:0] n_val;
  logic                  has_one, has_two, is_full;

  assign addr_top = count_reg[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign addr_n   = count_reg[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);
  assign has_one  = (count_reg >= PTR_WIDTH'(1));
  assign has_two  = (count_reg >= PTR_WIDTH'(2));
  assign is_full  = (count_reg == PTR_WIDTH'(DEPTH));

  // Masking keeps stale cells above the live region from ever reaching Y.
  assign n_val = has_two ? mem[addr_n] : '0;

  always_comb begin
    t_next     = t_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_addr    = addr_top;
    wr_data    = t_reg;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    unique case (op_e'(bus.op))
      OP_PUSH: begin
        if (!is_full) begin
          wr_en      = has_one;
          t_next     = bus.din;
          count_next = count_reg + PTR_WIDTH'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (has_one) begin
          t_next     = n_val;
          count_next = count_reg - PTR_WIDTH'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (has_one) t_next = bus.din;
        else         unf_set = 1'b1;
      end
      OP_COLLAPSE: begin
        if (has_two) begin
          t_next     = bus.din;
          count_next = count_reg - PTR_WIDTH'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_SWAP: begin
        if (has_two) begin
          t_next  = n_val;
          wr_en   = 1'b1;
          wr_addr = addr_n;
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase

    // A fault in the same cycle as err_clr leaves the flag set.
    overflow_next  = ovf_set | (overflow_reg  & ~bus.err_clr);
    underflow_next = unf_set | (underflow_reg & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_reg         <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      t_reg         <= t_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Cell array is left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign bus.T         = t_reg;
  assign bus.N         = n_val;
  assign bus.count     = count_reg;
  assign bus.empty     = (count_reg == '0);
  assign bus.full      = is_full;
  assign bus.tz        = (t_reg == '0);
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: linear sequence of stack operations with
// hand-computed expectations checked by immediate assertions.
module tb_data_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [2:0] HOLD = 3'b000, PUSH = 3'b001, POP = 3'b010,
                         REPL = 3'b011, COLL = 3'b100, SWAP = 3'b101;

  data_stack_if #(.DATA_WIDTH(16), .PTR_WIDTH(5)) bus ();

  data_stack #(.DATA_WIDTH(16), .DEPTH(16), .PTR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ts(input string tag, input logic [15:0] t, input logic [15:0] n,
                          input logic [4:0] cnt);
    check({tag, ".T"}, 32'(bus.T), 32'(t));
    check({tag, ".N"}, 32'(bus.N), 32'(n));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 5'd0));
    check({tag, ".full"}, 32'(bus.full), 32'(cnt == 5'd16));
    check({tag, ".tz"}, 32'(bus.tz), 32'(t == 16'h0));
    $display("step %-10s T=%04h N=%04h count=%0d ovf=%0b unf=%0b",
             tag, bus.T, bus.N, bus.count, bus.overflow, bus.underflow);
  endtask

  task automatic step(input logic [2:0] o, input logic [15:0] d, input logic c);
    bus.op      = o;
    bus.din     = d;
    bus.err_clr = c;
    @(posedge clk);
    #1;
    bus.op      = HOLD;
    bus.din     = 16'h0;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bus.op      = HOLD;
    bus.din     = 16'h0;
    bus.err_clr = 1'b0;
    #2;
    check_ts("reset", 16'h0, 16'h0, 5'd0);
    check("reset.ovf", 32'(bus.overflow), 32'd0);
    check("reset.unf", 32'(bus.underflow), 32'd0);
    #10 rst = 1'b0;

    // Three pushes, collapse, swap
    step(PUSH, 16'h0011, 1'b0);
    step(PUSH, 16'h0022, 1'b0);
    step(PUSH, 16'h0033, 1'b0);
    check_ts("push3", 16'h0033, 16'h0022, 5'd3);
    step(COLL, 16'h0055, 1'b0);
    check_ts("collapse", 16'h0055, 16'h0011, 5'd2);
    step(SWAP, 16'h0, 1'b0);
    check_ts("swap", 16'h0011, 16'h0055, 5'd2);

    // PUSH immediately followed by SWAP reading the just-written cell
    do_reset();
    step(PUSH, 16'h0007, 1'b0);
    step(PUSH, 16'h0008, 1'b0);
    step(SWAP, 16'h0, 1'b0);
    check_ts("push_swap", 16'h0007, 16'h0008, 5'd2);

    // Fill to capacity, overflow, drain
    do_reset();
    for (int i = 1; i <= 16; i++) step(PUSH, 16'(i), 1'b0);
    check_ts("fill", 16'd16, 16'd15, 5'd16);
    step(PUSH, 16'hBEEF, 1'b0);
    check_ts("push_full", 16'd16, 16'd15, 5'd16);
    check("push_full.ovf", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(POP, 16'h0, 1'b0);
      check_ts($sformatf("pop%0d", i), 16'(16 - i),
               (16 - i >= 2) ? 16'(15 - i) : 16'h0, 5'(16 - i));
    end
    check("drain.ovf_sticky", 32'(bus.overflow), 32'd1);
    check("drain.unf", 32'(bus.underflow), 32'd0);
    step(HOLD, 16'h0, 1'b1);
    check("clr.ovf", 32'(bus.overflow), 32'd0);

    // Underflow on empty stack
    step(POP, 16'h1234, 1'b0);
    check("pop_empty.unf", 32'(bus.underflow), 32'd1);
    check_ts("pop_empty", 16'h0, 16'h0, 5'd0);
    step(REPL, 16'h1234, 1'b0);
    check_ts("repl_empty", 16'h0, 16'h0, 5'd0);
    step(SWAP, 16'h1234, 1'b0);
    check_ts("swap_empty", 16'h0, 16'h0, 5'd0);
    check("swap_empty.unf", 32'(bus.underflow), 32'd1);
    check("swap_empty.ovf", 32'(bus.overflow), 32'd0);
    step(HOLD, 16'h0, 1'b1);
    check("clr.unf", 32'(bus.underflow), 32'd0);
    step(POP, 16'h0, 1'b1);
    check("clr_and_fault.unf", 32'(bus.underflow), 32'd1);
    step(COLL, 16'h9999, 1'b1);
    check("coll_empty.unf", 32'(bus.underflow), 32'd1);
    check_ts("coll_empty", 16'h0, 16'h0, 5'd0);
    step(HOLD, 16'h0, 1'b1);
    check("clr2.unf", 32'(bus.underflow), 32'd0);

    // Single-cell cases
    step(PUSH, 16'h00AA, 1'b0);
    step(SWAP, 16'h0, 1'b0);
    check_ts("swap_one", 16'h00AA, 16'h0, 5'd1);
    check("swap_one.unf", 32'(bus.underflow), 32'd1);
    step(COLL, 16'h4321, 1'b1);
    check_ts("coll_one", 16'h00AA, 16'h0, 5'd1);
    check("coll_one.unf", 32'(bus.underflow), 32'd1);
    step(HOLD, 16'h0, 1'b1);
    step(REPL, 16'h0000, 1'b0);
    check_ts("repl_zero", 16'h0, 16'h0, 5'd1);
    check("repl_zero.unf", 32'(bus.underflow), 32'd0);
    step(3'b110, 16'h5A5A, 1'b0);
    check_ts("op110", 16'h0, 16'h0, 5'd1);
    step(3'b111, 16'hA5A5, 1'b0);
    check_ts("op111", 16'h0, 16'h0, 5'd1);
    check("rsvd.unf", 32'(bus.underflow), 32'd0);
    check("rsvd.ovf", 32'(bus.overflow), 32'd0);
    step(REPL, 16'h00C3, 1'b0);
    check_ts("repl", 16'h00C3, 16'h0, 5'd1);

    // Asynchronous reset between edges
    for (int i = 2; i <= 5; i++) step(PUSH, 16'(i * 16'h0101), 1'b0);
    check_ts("count5", 16'h0505, 16'h0404, 5'd5);
    #2 rst = 1'b1;
    #1;
    check_ts("async_rst", 16'h0, 16'h0, 5'd0);
    #2 rst = 1'b0;
    step(PUSH, 16'h00F0, 1'b0);
    check_ts("post_rst", 16'h00F0, 16'h0, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
